load_store_unit: RTL and testbench

//  Sits directly upstream of dmem, between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane.sv | 50 +++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment/legality check used at request accept.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } lsu_state_t;

  // Illegal size, or a half/word access that is not naturally aligned.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           ((size == SIZE_H) && addr_lo[0]) ||
           ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane handling: extracts and extends load data from a memory word,
// and merges sub-word store data into a memory word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    case (size)
      SIZE_B:  load_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      SIZE_H:  load_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    if (size == SIZE_B) begin
      case (addr_lo)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (size == SIZE_H) begin
      if (addr_lo[1]) merged[31:16] = wdata;
      else            merged[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-only dmem: checks alignment, runs
// read, write or read-modify-write cycles, and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Request/response handshakes: a transfer happens on a rising edge where
  // valid and ready are both high; a raised valid holds its payload until then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_e,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output lsu_state_t        dbg_state
);

  lsu_state_t        state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              store_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merged;
  logic              req_bad;

  assign req_bad   = is_bad_access(req_size, req_addr[1:0]);
  assign dbg_state = state;

  lsu_lane u_lane (
    .word        (mem_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q[15:0]),
    .load_data   (lane_load),
    .merged      (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                                state_next = RESP;
          else if (req_store && (req_size == SIZE_W)) state_next = WRITE;
          else                                        state_next = READ;
        end
      end
      READ:    state_next = CAPT;
      CAPT:    state_next = store_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= SIZE_B;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            store_q    <= req_store;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            resp_err   <= req_bad;
            resp_rdata <= '0;
          end
        end
        // Read data from dmem is only valid in this cycle.
        CAPT: begin
          if (store_q) merge_q    <= lane_merged;
          else         resp_rdata <= lane_load;
        end
        RESP: begin
          if (resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_e      = (state == READ) || (state == WRITE);
    mem_rw     = (state == WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_e) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (state == WRITE) mem_wdata = (size_q == SIZE_W) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural dmem, byte-array reference model,
// directed scenarios and a randomized request stream.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_e, mem_rw;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  lsu_state_t  dbg_state;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem[1024];
  logic [31:0] dmem[256];
  int          wr_cnt, rd_cnt;
  logic [9:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_e(mem_e), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // dmem: word writes, registered reads, cleared by reset
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_e) begin
      if (mem_rw) begin
        dmem[mem_addr[9:2]] <= mem_wdata;
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_wdata;
      end else begin
        mem_rdata <= dmem[mem_addr[9:2]];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  function automatic void ref_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [9:0] ad);
    int a;
    a = {22'd0, ad[9:2], 2'b00};
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Little-endian byte-addressed memory; updates ref_mem for stores.
  function automatic void ref_access(input logic st, input logic [1:0] sz, input logic un,
                                     input logic [9:0] ad, input logic [31:0] wd,
                                     output logic err, output logic [31:0] data,
                                     output int lat, output int wrs, output int rds);
    int nbytes;
    int a;
    logic [31:0] v;
    a    = int'(ad);
    err  = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    data = 32'h0;
    wrs  = 0;
    rds  = 0;
    lat  = 1;
    if (err) return;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (st) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a+i] = wd[8*i +: 8];
      wrs = 1;
      rds = (nbytes < 4) ? 1 : 0;
      lat = (nbytes < 4) ? 4 : 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[a+i];
      if (!un && v[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) v[8*i +: 8] = 8'hFF;
      data = v;
      rds  = 1;
      lat  = 3;
    end
  endfunction

  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [9:0] ad, input logic [31:0] wd, input int hold,
                        output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_data, exp_data, snap;
    int          e_lat, e_wrs, e_rds, lat;
    logic        seen;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    wr_cnt = 0; rd_cnt = 0;
    req_store = st; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1; resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_access(st, sz, un, ad, wd, e_err, e_data, e_lat, e_wrs, e_rds);
    exp_q.push_back(e_data);
    lat = 0; seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(negedge clk);
      lat++;
      seen = resp_valid;
    end
    exp_data = exp_q.pop_front();
    got = resp_rdata;
    tests_run++;
    if (!seen || lat != e_lat) begin
      tests_failed++;
      $display("FAIL latency addr=%h size=%0d st=%b: got %0d (seen=%b) want %0d", ad, sz, st, lat, seen, e_lat);
    end
    tests_run++;
    if (resp_err !== e_err || resp_rdata !== exp_data) begin
      tests_failed++;
      $display("FAIL resp addr=%h size=%0d st=%b un=%b: got err=%b data=%h want err=%b data=%h",
               ad, sz, st, un, resp_err, resp_rdata, e_err, exp_data);
    end
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_ready_busy: got %b want 0", req_ready);
    end
    snap = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1 || resp_rdata !== snap || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL resp_hold cycle %0d: got valid=%b data=%h ready=%b want 1 %h 0",
                 i, resp_valid, resp_rdata, req_ready, snap);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (wr_cnt != e_wrs || rd_cnt != e_rds) begin
      tests_failed++;
      $display("FAIL strobes addr=%h size=%0d st=%b: got wr=%0d rd=%0d want wr=%0d rd=%0d",
               ad, sz, st, wr_cnt, rd_cnt, e_wrs, e_rds);
    end
    if (e_wrs == 1) begin
      tests_run++;
      if (last_wr_addr !== {ad[9:2], 2'b00} || last_wr_data !== ref_word(ad)) begin
        tests_failed++;
        $display("FAIL write_word: got addr=%h data=%h want addr=%h data=%h",
                 last_wr_addr, last_wr_data, {ad[9:2], 2'b00}, ref_word(ad));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    tests_run++;
    if (dbg_state !== IDLE || {req_ready, resp_valid, resp_err, mem_e, mem_rw} !== 5'b10000 ||
        resp_rdata !== 32'h0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s: got state=%0d rdy=%b v=%b err=%b e=%b rw=%b rd=%h ma=%h wd=%h want idle/1/0s",
               tag, dbg_state, req_ready, resp_valid, resp_err, mem_e, mem_rw, resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    ref_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_values");
  endtask

  task automatic test_word_access();
    logic [31:0] got;
    do_req(1'b1, SIZE_W, 1'b0, 10'h010, 32'hDEADBEEF, 0, got);
    do_req(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL load_word_010: got %h want deadbeef", got);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] got;
    do_req(1'b1, SIZE_B, 1'b0, 10'h012, 32'h0000005A, 0, got);
    do_req(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'hDE5ABEEF) begin
      tests_failed++;
      $display("FAIL merged_word: got %h want de5abeef", got);
    end
    do_req(1'b0, SIZE_B, 1'b0, 10'h012, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'h0000005A) begin
      tests_failed++;
      $display("FAIL load_byte_012: got %h want 0000005a", got);
    end
    do_req(1'b1, SIZE_H, 1'b0, 10'h01E, 32'h00008001, 0, got);
    do_req(1'b0, SIZE_H, 1'b0, 10'h01E, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'hFFFF8001) begin
      tests_failed++;
      $display("FAIL load_half_signed: got %h want ffff8001", got);
    end
    do_req(1'b0, SIZE_H, 1'b1, 10'h01E, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'h00008001) begin
      tests_failed++;
      $display("FAIL load_half_unsigned: got %h want 00008001", got);
    end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    do_req(1'b0, SIZE_W, 1'b0, 10'h013, 32'h0, 0, got);
    do_req(1'b1, 2'b11, 1'b0, 10'h020, 32'h12345678, 0, got);
    do_req(1'b1, SIZE_H, 1'b0, 10'h021, 32'h0000ABCD, 0, got);
    do_req(1'b0, SIZE_W, 1'b0, 10'h020, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'h0) begin
      tests_failed++;
      $display("FAIL err_no_write: got %h want 00000000", got);
    end
  endtask

  task automatic test_backpressure();
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat, e_wrs, e_rds, lat;
    logic        seen;
    @(negedge clk);
    req_store = 1'b0; req_size = SIZE_W; req_unsigned = 1'b0; req_addr = 10'h010;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_access(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0, e_err, e_data, e_lat, e_wrs, e_rds);
    lat = 0; seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(negedge clk); lat++; seen = resp_valid;
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (resp_valid !== 1'b1 || resp_rdata !== e_data || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d: got v=%b data=%h rdy=%b want 1 %h 0",
                 i, resp_valid, resp_rdata, req_ready, e_data);
      end
      if (i < 4) @(negedge clk);
    end
    // release and offer the next request in the same cycle
    resp_ready = 1'b1;
    req_valid = 1'b1; req_size = SIZE_B; req_unsigned = 1'b1; req_addr = 10'h013;
    @(posedge clk); #1;
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL bp_release: got state %0d want IDLE", dbg_state);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (dbg_state !== READ) begin
      tests_failed++;
      $display("FAIL bp_next_accept: got state %0d want READ", dbg_state);
    end
    ref_access(1'b0, SIZE_B, 1'b1, 10'h013, 32'h0, e_err, e_data, e_lat, e_wrs, e_rds);
    lat = 0; seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(negedge clk); lat++; seen = resp_valid;
    end
    tests_run++;
    if (!seen || resp_rdata !== e_data || e_data !== 32'h000000DE) begin
      tests_failed++;
      $display("FAIL bp_next_data: got v=%b data=%h want 1 000000de", seen, resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_write();
    logic [31:0] got;
    logic        in_write;
    do_req(1'b1, SIZE_W, 1'b0, 10'h040, 32'h11223344, 0, got);
    @(negedge clk);
    req_store = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0; req_addr = 10'h041;
    req_wdata = 32'h00000077; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    in_write = 1'b0;
    for (int i = 0; i < 10 && !in_write; i++) begin
      @(negedge clk);
      in_write = mem_e && mem_rw;
    end
    tests_run++;
    if (!in_write) begin
      tests_failed++;
      $display("FAIL rst_reach_write: got no write strobe want one");
    end
    reset = 1'b1;
    ref_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_in_write");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_no_resp cycle %0d: got resp_valid=%b want 0", i, resp_valid);
      end
    end
    do_req(1'b0, SIZE_W, 1'b0, 10'h040, 32'h0, 0, got);
    tests_run++;
    if (got !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mem_cleared: got %h want 00000000", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), got);
    end
  endtask

  initial begin
    test_reset();
    test_word_access();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_in_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
